bram_heap_enqueue: RTL

Insert-side engine for the BRAM-backed binary max-heap. Accepts one value at a time, places it at the tail slot (index = current size), and sifts it upward toward the root until its parent is not smaller. Storage is a true-dual-port read-first BRAM. The block keeps the live element count and a registered copy of the root. It is the enqueue counterpart to the root-replace/sift-down dequeue path and shares the same array layout: node i has children 2i+1 and 2i+2, and index 0 is the maximum.

---
 rtl/bram_heap_pkg.sv | 37 +++
 rtl/bram_heap_enqueue_ram.sv | 41 ++++
 rtl/bram_heap_enqueue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bram_heap_pkg.sv
// Shared definitions for the BRAM-backed binary max-heap engines.
// Node i has children 2i+1 and 2i+2; index 0 is the root (maximum).
package bram_heap_pkg;

  // Sift-engine states. The dequeue engine uses the same encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    WRITE = 3'd4
  } state_t;

  // Number of tree levels needed to hold queue_size elements.
  function automatic int tree_depth(input int queue_size);
    return $clog2(queue_size + 1);
  endfunction

  // Node count of a complete tree of that depth.
  function automatic int heap_nodes(input int queue_size);
    return (1 << tree_depth(queue_size)) - 1;
  endfunction

  // Index helpers. parent_idx(0) returns 0.
  function automatic int parent_idx(input int i);
    return (i - 1) / 2;
  endfunction

  function automatic int left_idx(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int right_idx(input int i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/bram_heap_enqueue_ram.sv
// True-dual-port, read-first block RAM with registered outputs.
// Contents are not reset; both ports share one write process so the
// array has a single driver. Simultaneous writes to one address are
// never issued by the heap engines (port B would win).
module rams_tdp_rf_rf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 7
) (
  input  logic                     CLK,
  input  logic                     en_a_i,
  input  logic                     we_a_i,
  input  logic [$clog2(DEPTH)-1:0] addr_a_i,
  input  logic [WIDTH-1:0]         din_a_i,
  output logic [WIDTH-1:0]         dout_a_o,
  input  logic                     en_b_i,
  input  logic                     we_b_i,
  input  logic [$clog2(DEPTH)-1:0] addr_b_i,
  input  logic [WIDTH-1:0]         din_b_i,
  output logic [WIDTH-1:0]         dout_b_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_a_q;
  logic [WIDTH-1:0] dout_b_q;

  // Read-first on both ports: dout captures the old word when writing.
  always_ff @(posedge CLK) begin
    if (en_a_i) begin
      if (we_a_i) mem[addr_a_i] <= din_a_i;
      dout_a_q <= mem[addr_a_i];
    end
    if (en_b_i) begin
      if (we_b_i) mem[addr_b_i] <= din_b_i;
      dout_b_q <= mem[addr_b_i];
    end
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule

// File: rtl/bram_heap_enqueue.sv
// Insert engine for the BRAM-backed max-heap. A new value is placed at the
// tail slot and sifted up using the hole method: parents smaller than the
// new value are moved down one level (port B), and the value itself is
// written once at its final slot (port A).
//
// state | meaning
// IDLE  | waiting for an insert; o_ready when not full
// READ  | port A addresses the parent of the hole
// WAIT  | BRAM read latency
// CMP   | compare value with parent; move parent down if smaller
// WRITE | write value into the hole; refresh top if at root
module bram_heap_enqueue
  import bram_heap_pkg::*;
#(
  parameter int QUEUE_SIZE = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            i_wrt,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_ready,
  output logic                            o_busy,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_size,
  output logic [DATA_WIDTH-1:0]           o_top
);

  localparam int NODES = heap_nodes(QUEUE_SIZE);
  localparam int AW    = $clog2(NODES);
  localparam int SW    = $clog2(QUEUE_SIZE + 1);

  state_t                state_q, state_d;
  logic [AW-1:0]         hole_q, hole_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [SW-1:0]         size_q, size_d;
  logic [DATA_WIDTH-1:0] top_q, top_d;

  logic                  full_w;
  logic                  ready_w;
  logic                  accept_w;
  logic [AW-1:0]         parent_w;

  logic                  we_a, we_b;
  logic [AW-1:0]         addr_a, addr_b;
  logic [DATA_WIDTH-1:0] din_a, din_b;
  logic [DATA_WIDTH-1:0] dout_a;
  logic [DATA_WIDTH-1:0] dout_b_unused;

  assign full_w   = (size_q == SW'(QUEUE_SIZE));
  assign ready_w  = (state_q == IDLE) && !full_w;
  assign accept_w = i_wrt && ready_w;
  assign parent_w = AW'(parent_idx(int'(hole_q)));

  // State and datapath registers; reset abandons any sift in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      hole_q  <= '0;
      val_q   <= '0;
      size_q  <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      hole_q  <= hole_d;
      val_q   <= val_d;
      size_q  <= size_d;
      top_q   <= top_d;
    end
  end

  // Next-state, datapath updates and BRAM port control.
  always_comb begin
    state_d = state_q;
    hole_d  = hole_q;
    val_d   = val_q;
    size_d  = size_q;
    top_d   = top_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    // Port A reads the parent by default so dout_a holds it through CMP.
    addr_a  = parent_w;
    din_a   = val_q;
    // Port B only ever moves a parent down into the current hole.
    addr_b  = hole_q;
    din_b   = dout_a;

    case (state_q)
      IDLE: begin
        if (accept_w) begin
          val_d   = i_data;
          hole_d  = AW'(size_q);
          size_d  = size_q + SW'(1);
          state_d = (size_q == '0) ? WRITE : READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: state_d = CMP;
      CMP: begin
        // Strict compare: equal values stay below the earlier insert.
        if (val_q > dout_a) begin
          we_b    = 1'b1;
          hole_d  = parent_w;
          state_d = (parent_w == '0) ? WRITE : READ;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        we_a    = 1'b1;
        addr_a  = hole_q;
        if (hole_q == '0) top_d = val_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rams_tdp_rf_rf #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (NODES)
  ) u_ram (
    .CLK      (CLK),
    .en_a_i   (1'b1),
    .we_a_i   (we_a),
    .addr_a_i (addr_a),
    .din_a_i  (din_a),
    .dout_a_o (dout_a),
    .en_b_i   (1'b1),
    .we_b_i   (we_b),
    .addr_b_i (addr_b),
    .din_b_i  (din_b),
    .dout_b_o (dout_b_unused)
  );

  assign o_ready = ready_w;
  assign o_busy  = (state_q != IDLE);
  assign o_full  = full_w;
  assign o_empty = (size_q == '0);
  assign o_size  = size_q;
  assign o_top   = top_q;

endmodule
